// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: fetch/execute sequencer that drives the PC register, flags fetch timeouts
// and counts retired instructions.
module pc_seq_ctrl #(
    parameter logic [3:0] MAX_WAIT = 4'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_q,
    input  logic        imem_ack,
    input  logic        halt_in,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] pc_next,
    output logic        pc_we,
    output logic        imem_req,
    output logic        instr_valid,
    output logic        halted,
    output logic        fetch_err,
    output logic [15:0] retire_cnt
);
    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        FETCH = 5'b00010,
        EXEC  = 5'b00100,
        HALT  = 5'b01000,
        ERR   = 5'b10000
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] retire_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wait_q   <= 4'd0;
            retire_q <= 16'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (pc_we) retire_q <= retire_q + 16'd1;
        end
    end

    // HALT and ERR are absorbing; any illegal encoding falls back to IDLE
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                wait_d  = imem_ack ? 4'd0 : wait_q + 4'd1;
                state_d = imem_ack ? EXEC : (wait_q == MAX_WAIT) ? ERR : FETCH;
            end
            EXEC:      state_d = halt_in ? HALT : stall ? EXEC : FETCH;
            HALT, ERR: state_d = state_q;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = state_q == FETCH;
        instr_valid = state_q == EXEC;
        halted      = state_q == HALT;
        fetch_err   = state_q == ERR;
        pc_we       = instr_valid && !halt_in && !stall;
        pc_next     = !pc_we ? pc_q : branch_taken ? {branch_target[15:1], 1'b0} : pc_q + 16'd2;
    end

    assign retire_cnt = retire_q;
endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4'd15: the maximum number of un-acknowledged fetch cycles before an error is flagged.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port pc_q, input, 16 bits: current PC, taken from the PC register output.
REQ-005 SHALL have port imem_ack, input, 1 bit: the instruction memory returned the word at pc_q.
REQ-006 SHALL have port halt_in, input, 1 bit: the decoded instruction is HLT.
REQ-007 SHALL have port stall, input, 1 bit: hazard hold; the current instruction must repeat.
REQ-008 SHALL have port branch_taken, input, 1 bit: redirect the PC to branch_target.
REQ-009 SHALL have port branch_target, input, 16 bits: redirect address.
REQ-010 SHALL have port pc_next, output, 16 bits: D input to the PC register.
REQ-011 SHALL have port pc_we, output, 1 bit: write enable to the PC register.
REQ-012 SHALL have port imem_req, output, 1 bit: fetch request for address pc_q.
REQ-013 SHALL have port instr_valid, output, 1 bit: the fetched instruction is being executed this cycle.
REQ-014 SHALL have port halted, output, 1 bit: the core is halted (sticky).
REQ-015 SHALL have port fetch_err, output, 1 bit: a fetch timeout occurred (sticky).
REQ-016 SHALL have port retire_cnt, output, 16 bits: count of retired instructions.

Function
REQ-017 SHALL implement a one-hot FSM with states IDLE, FETCH, EXEC, HALT and ERR, plus a 4-bit wait counter wait_cnt.
REQ-018 SHALL move IDLE->FETCH unconditionally on the first clock edge after reset deasserts.
REQ-019 SHALL, in FETCH, drive imem_req=1.
- imem_ack=1: go to EXEC and clear wait_cnt.
- Otherwise: increment wait_cnt.
- If wait_cnt==MAX_WAIT and imem_ack=0: go to ERR.
REQ-020 SHALL, in EXEC, drive instr_valid=1 and imem_req=0, and resolve inputs with priority halt_in > stall > branch_taken > sequential.
REQ-021 SHALL, for halt_in in EXEC: pc_we=0 and next state HALT; the PC is not advanced and the HLT instruction does not retire.
REQ-022 SHALL, for stall (without halt_in) in EXEC: pc_we=0 and the FSM remains in EXEC, with instr_valid held at 1.
REQ-023 SHALL, for branch_taken in EXEC: pc_we=1, pc_next={branch_target[15:1],1'b0} (forced halfword alignment), and next state FETCH.
REQ-024 SHALL, for the sequential case in EXEC: pc_we=1, pc_next=pc_q+16'd2 modulo 2^16 (16'hFFFE wraps to 16'h0000), and next state FETCH.
REQ-025 SHALL generate pc_we and pc_next combinationally from the state and inputs; in every state other than EXEC, pc_we=0 and pc_next=pc_q.
REQ-026 SHALL increment retire_cnt by 1 on each clock edge where pc_we=1, wrapping 16'hFFFF->16'h0000.
REQ-027 SHALL treat HALT and ERR as absorbing states, left only by reset.
- HALT: halted=1.
- ERR: fetch_err=1.
- Both: imem_req=0, pc_we=0, instr_valid=0.
REQ-028 SHALL ignore imem_ack outside FETCH and ignore halt_in, stall and branch_taken outside EXEC.

Reset
REQ-029 SHALL, while rst=0 (immediately and asynchronously, including mid-fetch or mid-stall), force state=IDLE, wait_cnt=0 and retire_cnt=0.
REQ-030 SHALL, while rst=0, force outputs imem_req=0, pc_we=0, instr_valid=0, halted=0, fetch_err=0 and pc_next=pc_q.
REQ-031 SHALL resume at IDLE on the first rising edge of clk after rst returns to 1; the PC register's own reset supplies pc_q=16'h0000.

Verification
REQ-032 SHALL be verified by a sequential-fetch scenario: pc_q=0, imem_ack asserted one cycle after each imem_req, 3 instructions -> PC sequence 0000, 0002, 0004, 0006, and retire_cnt=3.
REQ-033 SHALL be verified by a branch-alignment scenario: EXEC with branch_taken=1, branch_target=16'h1235, stall=0 -> pc_we=1, pc_next=16'h1234, next state FETCH.
REQ-034 SHALL be verified by a stall-then-halt scenario: stall=1 for 3 EXEC cycles, then halt_in=1 -> pc_we=0 throughout, instr_valid=1 for 4 cycles, then halted=1 sticky and retire_cnt unchanged.
REQ-035 SHALL be verified by a wrap-around scenario: pc_q=16'hFFFE sequential retire -> pc_next=16'h0000; retire_cnt=16'hFFFF plus one retire -> 16'h0000.
REQ-036 SHALL be verified by a timeout scenario: imem_ack held 0 in FETCH -> fetch_err=1 after exactly MAX_WAIT+1 cycles (16 with the default), and imem_req=0 afterwards.
REQ-037 SHALL be verified by an asynchronous-reset scenario: rst=0 asserted mid-stall and mid-fetch, between clock edges -> all outputs reach their reset values without waiting for a clock edge, and fetch restarts via IDLE after release.
